// File: rtl/full_adder4_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : full_adder4_reg                                           |
// | Purpose  : Registered WIDTH-bit ripple-carry adder with carry in/out |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+

module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_p;

    assign w_p = x ^ y;
    assign s   = w_p ^ ci;
    assign co  = (x & y) | (ci & w_p);
endmodule

module full_adder4_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] so,
    output logic             co,
    output logic             out_valid
);
    // w_carry[i] is the carry into cell i; w_carry[WIDTH] leaves the chain
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_so;
    logic             r_co;
    logic             r_out_valid;

    assign w_carry[0] = c;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_cell (
                .x  (a[gi]),
                .y  (b[gi]),
                .ci (w_carry[gi]),
                .s  (w_sum[gi]),
                .co (w_carry[gi+1])
            );
        end
    endgenerate

    // Sum/carry hold while idle; only out_valid drops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_so        <= '0;
            r_co        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_so <= w_sum;
                r_co <= w_carry[WIDTH];
            end
        end
    end

    assign so        = r_so;
    assign co        = r_co;
    assign out_valid = r_out_valid;
endmodule

`default_nettype wire

// File: tb/tb_full_adder4_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_full_adder4_reg                                        |
// | Purpose  : Directed, table-driven self-checking bench for the adder  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+

module tb_full_adder4_reg;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic       in_valid;
    logic [3:0] so;
    logic       co;
    logic       out_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] so;
        logic       co;
        logic       ov;
    } vec_t;

    localparam int c_NVEC = 9;
    vec_t vecs [c_NVEC];

    full_adder4_reg #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .in_valid  (in_valid),
        .so        (so),
        .co        (co),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
        end
    endtask

    // Apply inputs, clock once, then sample 1ns after the edge
    task automatic step(input logic r, input logic iv, input logic [3:0] aa,
                        input logic [3:0] bb, input logic cc);
        rst      = r;
        in_valid = iv;
        a        = aa;
        b        = bb;
        c        = cc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string nm, input logic [3:0] eso,
                             input logic eco, input logic eov);
        check({nm, ".so"}, so, eso);
        check({nm, ".co"}, {3'b0, co}, {3'b0, eco});
        check({nm, ".ov"}, {3'b0, out_valid}, {3'b0, eov});
    endtask

    initial begin
        //          rst   iv    a      b      c     so     co    ov
        vecs[0] = '{1'b1, 1'b1, 4'd5,  4'd2,  1'b0, 4'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'd5,  4'd2,  1'b0, 4'h0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 4'd5,  4'd2,  1'b0, 4'h7, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 4'd10, 4'd8,  1'b0, 4'h2, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 4'd15, 4'd0,  1'b1, 4'h0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 4'h0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 4'd0,  4'd0,  1'b1, 4'h1, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 4'd10, 4'd8,  1'b0, 4'h2, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = 1'b0;
        #2;

        for (int i = 0; i < c_NVEC; i++) begin
            step(vecs[i].rst, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].c);
            check_out($sformatf("vec%0d", i), vecs[i].so, vecs[i].co, vecs[i].ov);
        end

        // Idle cycles with garbage operands must hold the last result
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)),
                 1'($urandom_range(1)));
            check_out($sformatf("idle%0d", i), 4'h2, 1'b1, 1'b0);
        end

        // Reset coinciding with a valid 9+9 discards it
        step(1'b1, 1'b1, 4'd9, 4'd9, 1'b0);
        check_out("rst_mid", 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd9, 4'd9, 1'b0);
        check_out("rst_after", 4'h0, 1'b0, 1'b0);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic [4:0] sum;
            v   = 9'(i);
            sum = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
            step(1'b0, 1'b1, v[3:0], v[7:4], v[8]);
            check_out($sformatf("exh%0d", i), sum[3:0], sum[4], 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
